alu_issue_stage: RTL and testbench

- Upstream operand-issue and writeback stage for the 32-bit combinational ALU (LHS/RHS/opp -> res).
- Holds an 8-entry x 32-bit register file and accepts commands over a valid/ready handshake.
- Per command: fetches operands, drives them registered onto the ALU inputs, captures the ALU result one cycle later, writes it back, and presents it on a valid/ready response port.
- Exactly one command is in flight at a time; no hazard logic is needed.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_stage_if.sv | 30 +++
 rtl/alu_regfile.sv | 44 ++++
 rtl/alu_issue_stage.sv | 128 ++++++++++++
 tb/tb_alu_issue_stage.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants, state encoding and opcode helpers for the ALU issue stage
// and anything that models the ALU it feeds.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_N  = 8;
    localparam int AW     = 3;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Codes above XOR have no ALU meaning and must not reach the register file.
    function automatic logic op_illegal(input logic [2:0] opp);
        return (opp > OP_XOR);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command and response handshake bundle between a requester and the issue stage.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opp;
    logic [AW-1:0]     cmd_src_a;
    logic [AW-1:0]     cmd_src_b;
    logic              cmd_imm_en;
    logic [DATA_W-1:0] cmd_imm;
    logic [AW-1:0]     cmd_dst;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [AW-1:0]     rsp_dst;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_opp, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm, cmd_dst, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_opp, cmd_src_a, cmd_src_b, cmd_imm_en, cmd_imm, cmd_dst, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_dst, rsp_err
    );

endinterface

// File: rtl/alu_regfile.sv
// REG_N x DATA_W register file: two asynchronous read ports, a writeback port
// that wins over the external load port on an address collision.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] mem_r [REG_N];

    assign ra_data = mem_r[ra_addr];
    assign rb_data = mem_r[rb_addr];

    // Storage update: per-entry decode so both ports can land on different entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                if (wb_en && (wb_addr == AW'(i))) begin
                    mem_r[i] <= wb_data;
                end else if (ld_en && (ld_addr == AW'(i))) begin
                    mem_r[i] <= ld_data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand issue / writeback stage wrapped around a combinational 32-bit ALU:
// one command in flight, IDLE -> EXEC -> RESP.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    alu_issue_stage_if.slave  bus,
    output logic [DATA_W-1:0] alu_lhs,
    output logic [DATA_W-1:0] alu_rhs,
    output logic [2:0]        alu_opp,
    input  logic [DATA_W-1:0] alu_res
);

    state_e            state_r, state_s;
    logic              accept_s;
    logic              wb_en_s;
    logic [DATA_W-1:0] ra_data_s, rb_data_s;
    logic [DATA_W-1:0] lhs_r, rhs_r;
    logic [2:0]        opp_r;
    logic [AW-1:0]     dst_r;
    logic              err_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [AW-1:0]     rsp_dst_r;
    logic              rsp_err_r;

    alu_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (bus.cmd_src_a),
        .ra_data (ra_data_s),
        .rb_addr (bus.cmd_src_b),
        .rb_data (rb_data_s),
        .wb_en   (wb_en_s),
        .wb_addr (dst_r),
        .wb_data (alu_res),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    assign accept_s      = (state_r == ST_IDLE) && bus.cmd_valid;
    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_dst   = rsp_dst_r;
    assign bus.rsp_err   = rsp_err_r;
    assign alu_lhs       = lhs_r;
    assign alu_rhs       = rhs_r;
    assign alu_opp       = opp_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and writeback enable; illegal commands never write back.
    always_comb begin
        state_s = state_r;
        wb_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_s = ST_RESP;
                wb_en_s = ~err_r;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Issue registers: operands are fetched from pre-edge register contents on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhs_r <= {DATA_W{1'b0}};
            rhs_r <= {DATA_W{1'b0}};
            opp_r <= 3'b000;
            dst_r <= {AW{1'b0}};
            err_r <= 1'b0;
        end else if (accept_s) begin
            lhs_r <= ra_data_s;
            rhs_r <= bus.cmd_imm_en ? bus.cmd_imm : rb_data_s;
            opp_r <= bus.cmd_opp;
            dst_r <= bus.cmd_dst;
            err_r <= op_illegal(bus.cmd_opp);
        end
    end

    // Response registers: capture at the end of EXEC, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_dst_r   <= {AW{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= alu_res;
            rsp_dst_r   <= dst_r;
            rsp_err_r   <= err_r;
        end else if ((state_r == ST_RESP) && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, vector table, scoreboard of
// expected responses, and hand sequences for stall, collision and reset cases.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] alu_lhs, alu_rhs, alu_res;
    logic [2:0]        alu_opp;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .bus     (bus),
        .alu_lhs (alu_lhs),
        .alu_rhs (alu_rhs),
        .alu_opp (alu_opp),
        .alu_res (alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the downstream ALU.
    always_comb begin
        case (alu_opp)
            OP_AND:  alu_res = alu_lhs & alu_rhs;
            OP_OR:   alu_res = alu_lhs | alu_rhs;
            OP_ADD:  alu_res = alu_lhs + alu_rhs;
            OP_NOT:  alu_res = ~alu_lhs;
            OP_SUB:  alu_res = alu_lhs - alu_rhs;
            OP_XOR:  alu_res = alu_lhs ^ alu_rhs;
            default: alu_res = ERR_PATTERN;
        endcase
    end

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [AW-1:0]     dst;
        logic              err;
    } exp_t;

    typedef struct {
        logic [2:0]        opp;
        logic [AW-1:0]     a;
        logic [AW-1:0]     b;
        logic              imm_en;
        logic [DATA_W-1:0] imm;
        logic [AW-1:0]     dst;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: compare whenever a handshake will occur at the next edge.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", bus.rsp_data, e.data);
                chk("rsp_dst", {29'd0, bus.rsp_dst}, {29'd0, e.dst});
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Offer a command; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] opp, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic imm_en, input logic [DATA_W-1:0] imm, input logic [AW-1:0] dst,
                         input logic [DATA_W-1:0] exp_d, input logic exp_e);
        bit ok;
        exp_t e;
        ok = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_opp = opp; bus.cmd_src_a = a; bus.cmd_src_b = b;
        bus.cmd_imm_en = imm_en; bus.cmd_imm = imm; bus.cmd_dst = dst;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                e.data = exp_d; e.dst = dst; e.err = exp_e;
                sb.push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ((sb.size() == 0) && bus.cmd_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic readback(input logic [AW-1:0] r, input logic [DATA_W-1:0] exp_d);
        issue(OP_OR, r, 3'd0, 1'b1, 32'd0, 3'd0, exp_d, 1'b0);
        drain();
    endtask

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = 3'd0; ld_data = 32'd0;
        bus.cmd_valid = 1'b0; bus.cmd_opp = 3'd0; bus.cmd_src_a = 3'd0; bus.cmd_src_b = 3'd0;
        bus.cmd_imm_en = 1'b0; bus.cmd_imm = 32'd0; bus.cmd_dst = 3'd0; bus.rsp_ready = 1'b1;

        tbl[0] = '{OP_ADD, 3'd1, 3'd2, 1'b0, 32'd0,          3'd3, 32'h0000_0008};
        tbl[1] = '{OP_SUB, 3'd1, 3'd2, 1'b0, 32'd0,          3'd4, 32'h0000_0002};
        tbl[2] = '{OP_OR,  3'd1, 3'd0, 1'b1, 32'h0000_0030, 3'd5, 32'h0000_0035};
        tbl[3] = '{OP_XOR, 3'd3, 3'd4, 1'b0, 32'd0,          3'd6, 32'h0000_000A};
        tbl[4] = '{OP_NOT, 3'd1, 3'd0, 1'b0, 32'd0,          3'd7, 32'hFFFF_FFFA};
        tbl[5] = '{OP_AND, 3'd7, 3'd0, 1'b1, 32'h0000_00FF, 3'd0, 32'h0000_00FA};
        tbl[6] = '{OP_ADD, 3'd3, 3'd0, 1'b1, 32'hFFFF_FFFF, 3'd6, 32'h0000_0007};
        tbl[7] = '{OP_SUB, 3'd0, 3'd0, 1'b1, 32'h0000_00FB, 3'd0, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_dst", {29'd0, bus.rsp_dst}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_alu_lhs", alu_lhs, 32'd0);
        chk("rst_alu_rhs", alu_rhs, 32'd0);
        chk("rst_alu_opp", {29'd0, alu_opp}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        load(3'd1, 32'h0000_0005);
        load(3'd2, 32'h0000_0003);
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].opp, tbl[i].a, tbl[i].b, tbl[i].imm_en, tbl[i].imm, tbl[i].dst, tbl[i].exp_data, 1'b0);
            drain();
        end

        // Chained read-after-write through the register file.
        load(3'd1, 32'd0);
        load(3'd2, 32'd1);
        issue(OP_SUB, 3'd1, 3'd2, 1'b0, 32'd0, 3'd4, 32'hFFFF_FFFF, 1'b0);
        drain();
        issue(OP_AND, 3'd4, 3'd0, 1'b1, 32'h0000_00F0, 3'd5, 32'h0000_00F0, 1'b0);
        drain();

        // Latency and back-pressure: a second command must wait for the consumer.
        bus.rsp_ready = 1'b0;
        issue(OP_ADD, 3'd1, 3'd2, 1'b0, 32'd0, 3'd3, 32'h0000_0001, 1'b0);
        chk("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.cmd_valid = 1'b1; bus.cmd_opp = OP_XOR; bus.cmd_src_a = 3'd4; bus.cmd_src_b = 3'd2;
        bus.cmd_imm_en = 1'b0; bus.cmd_dst = 3'd6;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("stall_rsp_data", bus.rsp_data, 32'h0000_0001);
            chk("stall_rsp_dst", {29'd0, bus.rsp_dst}, 32'd3);
            chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("stall_alu_opp", {29'd0, alu_opp}, {29'd0, OP_ADD});
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        begin
            exp_t e;
            e.data = 32'hFFFF_FFFE; e.dst = 3'd6; e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        chk("second_accepted", {31'd0, bus.cmd_ready}, 32'd0);
        chk("second_alu_opp", {29'd0, alu_opp}, {29'd0, OP_XOR});
        bus.cmd_valid = 1'b0;
        drain();

        // Illegal operator: issued, flagged, no writeback.
        load(3'd5, 32'h0000_1234);
        issue(3'b111, 3'd1, 3'd2, 1'b0, 32'd0, 3'd5, ERR_PATTERN, 1'b1);
        drain();
        readback(3'd5, 32'h0000_1234);

        // Load colliding with writeback: same address loses, different address lands.
        load(3'd1, 32'h0000_0010);
        load(3'd2, 32'h0000_0020);
        issue(OP_ADD, 3'd1, 3'd2, 1'b0, 32'd0, 3'd3, 32'h0000_0030, 1'b0);
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 32'h0000_AAAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        drain();
        readback(3'd3, 32'h0000_0030);
        issue(OP_SUB, 3'd2, 3'd1, 1'b0, 32'd0, 3'd3, 32'h0000_0010, 1'b0);
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'h0000_AAAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        drain();
        readback(3'd6, 32'h0000_AAAA);
        readback(3'd3, 32'h0000_0010);

        // Reset while holding a response.
        bus.rsp_ready = 1'b0;
        issue(OP_ADD, 3'd1, 3'd2, 1'b0, 32'd0, 3'd7, 32'h0000_0030, 1'b0);
        @(posedge clk); #1;
        chk("resp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("async_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("async_alu_lhs", alu_lhs, 32'd0);
        sb.delete();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        readback(3'd1, 32'd0);
        readback(3'd2, 32'd0);
        readback(3'd7, 32'd0);
        readback(3'd5, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
